spi_frame_scheduler: RTL and testbench

//  Sequences the SPI slave serializer: gathers 16-bit samples from NUM_CH ADC channel

---
 rtl/spi_frame_scheduler_if.sv | 31 +++
 rtl/spi_frame_scheduler.sv | 172 +++++++++++++++++
 tb/tb_spi_frame_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_scheduler_if.sv
// Bus between the frame scheduler, the ADC channel holding registers and the
// SPI slave serializer. The scheduler is the master: it consumes channel
// samples and launches words into the serializer.
interface spi_frame_scheduler_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]    ch_valid;   // channel i holds a sample
    logic [16*NUM_CH-1:0] ch_data;    // sample of channel i at [16*i +: 16]
    logic [NUM_CH-1:0]    ch_ack;     // 1-cycle pulse: channel i word consumed
    logic                 tx_ready;   // serializer ready_for_data
    logic                 tx_start;   // serializer Indata_valid pulse
    logic [15:0]          tx_word;    // serializer unprocessed_MISO

    modport master (
        input  ch_valid,
        input  ch_data,
        input  tx_ready,
        output ch_ack,
        output tx_start,
        output tx_word
    );

    modport slave (
        output ch_valid,
        output ch_data,
        output tx_ready,
        input  ch_ack,
        input  tx_start,
        input  tx_word
    );
endinterface

// File: rtl/spi_frame_scheduler.sv
// spi_frame_scheduler: gathers one 16-bit sample per ready ADC channel and
// feeds the SPI slave serializer one frame per burst -- a header word
// {4'hA, seq, channel mask}, then each captured channel word in ascending
// channel order. Each word is launched only when the serializer is ready, and
// the serializer must drop ready within BUSY_TMO cycles or the frame aborts.
module spi_frame_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int BUSY_TMO = 4
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  enable,
    spi_frame_scheduler_if.master bus,
    output logic                  frame_active,
    output logic                  frame_done,
    output logic                  err_timeout
);
    localparam int CNT_W = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("spi_frame_scheduler: NUM_CH must be in 1..8");
    end
    if (BUSY_TMO < 1) begin : g_bad_busy_tmo
        $error("spi_frame_scheduler: BUSY_TMO must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,   // waiting for enable, a valid channel and a ready serializer
        WAIT_BUSY = 2'd1,   // word launched; waiting for the serializer to go busy
        WAIT_DONE = 2'd2    // serializer busy; waiting for it to finish the word
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [3:0]          seq_q, seq_d;
    logic [15:0]         tx_word_q, tx_word_d;
    logic                tx_start_q, tx_start_d;
    logic [NUM_CH-1:0]   ch_ack_q, ch_ack_d;
    logic                frame_active_q, frame_active_d;
    logic                frame_done_q, frame_done_d;
    logic                err_timeout_q, err_timeout_d;

    logic [IDX_W-1:0]    sel_idx;
    logic [NUM_CH-1:0]   sel_oh;
    logic [15:0]         sel_word;
    logic [7:0]          hdr_mask;

    // Pick the lowest pending channel of the frame and its sample word.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        sel_oh   = mask_q & (~mask_q + NUM_CH'(1));
        sel_word = bus.ch_data[{sel_idx, 4'b0000} +: 16];
    end

    // Zero-extend the live channel-valid snapshot into the header mask field.
    always_comb begin
        hdr_mask               = '0;
        hdr_mask[NUM_CH-1:0]   = bus.ch_valid;
    end

    // Frame sequencing: next state, next counters and next registered outputs.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        mask_d         = mask_q;
        seq_d          = seq_q;
        tx_word_d      = tx_word_q;
        tx_start_d     = 1'b0;
        ch_ack_d       = '0;
        frame_active_d = frame_active_q;
        frame_done_d   = 1'b0;
        err_timeout_d  = err_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (enable && (|bus.ch_valid) && bus.tx_ready) begin
                    mask_d         = bus.ch_valid;
                    tx_word_d      = {4'hA, seq_q, hdr_mask};
                    tx_start_d     = 1'b1;
                    frame_active_d = 1'b1;
                    cnt_d          = '0;
                    state_d        = WAIT_BUSY;
                end
            end

            WAIT_BUSY: begin
                if (!bus.tx_ready) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TMO - 1)) begin
                    // Serializer never took the word: abandon the frame and
                    // leave the untransmitted channels un-acked.
                    err_timeout_d  = 1'b1;
                    frame_active_d = 1'b0;
                    mask_d         = '0;
                    cnt_d          = '0;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WAIT_DONE: begin
                if (bus.tx_ready) begin
                    if (|mask_q) begin
                        tx_word_d  = sel_word;
                        tx_start_d = 1'b1;
                        ch_ack_d   = sel_oh;
                        mask_d     = mask_q & ~sel_oh;
                        cnt_d      = '0;
                        state_d    = WAIT_BUSY;
                    end else begin
                        frame_done_d   = 1'b1;
                        frame_active_d = 1'b0;
                        seq_d          = seq_q + 4'd1;
                        state_d        = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge sclk) begin
        // NOTE: reset is sampled on the clock edge, so it wins over any launch
        // or ack that would otherwise have happened in that same cycle.
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            mask_q         <= '0;
            seq_q          <= 4'd0;
            tx_word_q      <= 16'h0000;
            tx_start_q     <= 1'b0;
            ch_ack_q       <= '0;
            frame_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mask_q         <= mask_d;
            seq_q          <= seq_d;
            tx_word_q      <= tx_word_d;
            tx_start_q     <= tx_start_d;
            ch_ack_q       <= ch_ack_d;
            frame_active_q <= frame_active_d;
            frame_done_q   <= frame_done_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign bus.tx_start  = tx_start_q;
    assign bus.tx_word   = tx_word_q;
    assign bus.ch_ack    = ch_ack_q;
    assign frame_active  = frame_active_q;
    assign frame_done    = frame_done_q;
    assign err_timeout   = err_timeout_q;
endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Bench for spi_frame_scheduler: directed scenarios plus a randomized phase,
// with a transaction-level reference model compared on every cycle and a
// serializer model that reacts to tx_start with a random busy time.
module tb_spi_frame_scheduler;
    localparam int NUM_CH   = 4;
    localparam int BUSY_TMO = 4;

    logic sclk = 1'b0;
    always #5 sclk = ~sclk;

    logic rst    = 1'b1;
    logic enable = 1'b0;
    logic frame_active, frame_done, err_timeout;

    spi_frame_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

    spi_frame_scheduler #(.NUM_CH(NUM_CH), .BUSY_TMO(BUSY_TMO)) dut (
        .sclk         (sclk),
        .rst          (rst),
        .enable       (enable),
        .bus          (bus),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .err_timeout  (err_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- serializer model ----------------
    bit ser_stuck    = 1'b0;   // never goes busy (forces a timeout)
    bit ser_hold_low = 1'b0;   // holds ready low
    int ser_lat_max  = 3;
    int busy_left    = 0;

    always @(posedge sclk) begin
        if (ser_hold_low) begin
            bus.tx_ready <= 1'b0;
        end else if (ser_stuck) begin
            bus.tx_ready <= 1'b1;
        end else if (bus.tx_start === 1'b1) begin
            bus.tx_ready <= 1'b0;
            busy_left = $urandom_range(ser_lat_max, 1);
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) bus.tx_ready <= 1'b1;
        end else begin
            bus.tx_ready <= 1'b1;
        end
    end

    // ---------------- reference model ----------------
    // A frame is a list of channels still to send; the model only tracks
    // whether it is waiting for the serializer to go busy (m_busy >= 0 counts
    // the cycles spent waiting) or to come back ready (m_busy < 0).
    bit               m_in_frame = 1'b0;
    int               m_busy     = 0;
    int               m_todo[$];
    logic [3:0]       m_seq      = 4'd0;
    logic             e_start = 1'b0, e_active = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [15:0]      e_word  = 16'h0;
    logic [NUM_CH-1:0] e_ack  = '0;

    always @(posedge sclk) begin
        e_start = 1'b0;
        e_ack   = '0;
        e_done  = 1'b0;
        if (rst) begin
            m_in_frame = 1'b0;
            m_busy     = 0;
            m_todo.delete();
            m_seq      = 4'd0;
            e_word     = 16'h0000;
            e_active   = 1'b0;
            e_err      = 1'b0;
        end else if (!m_in_frame) begin
            if (enable && (bus.ch_valid != '0) && bus.tx_ready === 1'b1) begin
                for (int i = 0; i < NUM_CH; i++)
                    if (bus.ch_valid[i]) m_todo.push_back(i);
                e_word     = {4'hA, m_seq, 8'(bus.ch_valid)};
                e_start    = 1'b1;
                e_active   = 1'b1;
                m_in_frame = 1'b1;
                m_busy     = 0;
            end
        end else if (m_busy >= 0) begin
            if (bus.tx_ready === 1'b0) begin
                m_busy = -1;
            end else begin
                m_busy++;
                if (m_busy == BUSY_TMO) begin
                    e_err      = 1'b1;
                    e_active   = 1'b0;
                    m_in_frame = 1'b0;
                    m_todo.delete();
                end
            end
        end else if (bus.tx_ready === 1'b1) begin
            if (m_todo.size() > 0) begin
                int ch;
                ch        = m_todo.pop_front();
                e_word    = bus.ch_data[16*ch +: 16];
                e_ack[ch] = 1'b1;
                e_start   = 1'b1;
                m_busy    = 0;
            end else begin
                e_done     = 1'b1;
                e_active   = 1'b0;
                m_seq      = m_seq + 4'd1;
                m_in_frame = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare and logging ----------------
    bit          chk_en = 1'b0;
    int          cyc    = 0;
    int          done_cnt = 0;
    logic [15:0] word_log[$];
    logic [15:0] hdr_log[$];
    logic [NUM_CH-1:0] ack_log[$];

    always @(negedge sclk) begin
        if (chk_en) begin
            check("tx_start",     bus.tx_start,  e_start);
            check("tx_word",      bus.tx_word,   e_word);
            check("ch_ack",       bus.ch_ack,    e_ack);
            check("frame_active", frame_active,  e_active);
            check("frame_done",   frame_done,    e_done);
            check("err_timeout",  err_timeout,   e_err);
            if (bus.tx_start === 1'b1) begin
                word_log.push_back(bus.tx_word);
                if (bus.ch_ack == '0) hdr_log.push_back(bus.tx_word);
            end
            if (bus.ch_ack != '0) ack_log.push_back(bus.ch_ack);
            if (frame_done === 1'b1) done_cnt++;
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [NUM_CH-1:0] auto_clear = '1;

    function automatic logic [15:0] wlog(input int k);
        return (k < word_log.size()) ? word_log[k] : 16'hxxxx;
    endfunction

    function automatic logic [15:0] hlog(input int k);
        return (k < hdr_log.size()) ? hdr_log[k] : 16'hxxxx;
    endfunction

    // Advance one cycle; inputs change 1ns after the falling edge. A channel
    // holding register drops its valid once its ack has been seen.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge sclk);
            #1;
            for (int i = 0; i < NUM_CH; i++)
                if (auto_clear[i] && bus.ch_ack[i] === 1'b1) bus.ch_valid[i] = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            step();
            n++;
        end
        check({name, "_frame_done_seen"}, done_cnt != start, 1);
    endtask

    task automatic wait_hdr(input string name, input int target, input int budget);
        int n = 0;
        while (hdr_log.size() < target && n < budget) begin
            step();
            n++;
        end
        check({name, "_header_seen"}, hdr_log.size() >= target, 1);
    endtask

    task automatic check_quiet(input string name);
        check({name, "_tx_start"},     bus.tx_start, 0);
        check({name, "_tx_word"},      bus.tx_word,  16'h0000);
        check({name, "_ch_ack"},       bus.ch_ack,   0);
        check({name, "_frame_active"}, frame_active, 0);
        check({name, "_frame_done"},   frame_done,   0);
        check({name, "_err_timeout"},  err_timeout,  0);
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NUM_CH; i++) bus.ch_data[16*i +: 16] = 16'($urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w0, a0, d0, h0, t_s, t_e;
        bus.ch_valid = '0;
        bus.ch_data  = '0;

        // Reset state
        rst = 1'b1;
        step(2);
        chk_en = 1'b1;
        step(1);
        check_quiet("reset");
        rst = 1'b0;
        step(2);

        // 1: basic frame, channels 0 and 2
        randomize_data();
        bus.ch_data[15:0]  = 16'h1234;
        bus.ch_data[47:32] = 16'hBEEF;
        w0 = word_log.size(); a0 = ack_log.size(); d0 = done_cnt;
        bus.ch_valid = 4'b0101;
        enable = 1'b1;
        wait_done("t1", 100);
        check("t1_word_count", word_log.size() - w0, 3);
        check("t1_header",     wlog(w0),     16'hA005);
        check("t1_word_ch0",   wlog(w0 + 1), 16'h1234);
        check("t1_word_ch2",   wlog(w0 + 2), 16'hBEEF);
        check("t1_ack_count",  ack_log.size() - a0, 2);
        check("t1_ack_first",  (ack_log.size() > a0)     ? ack_log[a0]     : 'x, 4'b0001);
        check("t1_ack_second", (ack_log.size() > a0 + 1) ? ack_log[a0 + 1] : 'x, 4'b0100);
        step(10);
        check("t1_done_once", done_cnt - d0, 1);

        // 2: back-to-back frames, seq wrap, late channel joins the next frame
        rst = 1'b1; step(1); rst = 1'b0;
        auto_clear = '0;
        h0 = hdr_log.size();
        bus.ch_valid = 4'b0001;
        enable = 1'b1;
        wait_hdr("t2_seq", h0 + 17, 17 * 20);
        for (int i = 0; i < 17; i++)
            check($sformatf("t2_header_%0d", i), hlog(h0 + i), {4'hA, 4'(i % 16), 8'h01});
        bus.ch_valid[3] = 1'b1;
        randomize_data();
        wait_hdr("t2_late", h0 + 18, 40);
        check("t2_late_ch3_header", hlog(h0 + 17), 16'hA109);
        enable = 1'b0;
        wait_done("t2", 60);
        bus.ch_valid = '0;
        auto_clear = '1;
        step(3);

        // 3: serializer never goes busy -> timeout
        ser_stuck = 1'b1;
        step(2);
        a0 = ack_log.size(); d0 = done_cnt; h0 = hdr_log.size();
        t_s = -1; t_e = -1;
        bus.ch_valid = 4'b0010;
        enable = 1'b1;
        for (int n = 0; n < 40 && t_e < 0; n++) begin
            step();
            if (t_s < 0 && bus.tx_start === 1'b1) t_s = cyc;
            if (err_timeout === 1'b1) begin
                t_e = cyc;
                enable = 1'b0;
            end
        end
        check("t3_header", hlog(h0), 16'hA202);
        check("t3_timeout_latency", t_e - t_s, BUSY_TMO);
        check("t3_frame_active", frame_active, 0);
        step(6);
        check("t3_err_sticky", err_timeout, 1);
        check("t3_no_ack", ack_log.size() - a0, 0);
        check("t3_no_done", done_cnt - d0, 0);
        check("t3_single_header", hdr_log.size() - h0, 1);
        ser_stuck = 1'b0;
        bus.ch_valid = '0;
        step(3);

        // 4: reset while waiting on a channel word
        rst = 1'b1; step(1); rst = 1'b0;
        check("t4_err_cleared", err_timeout, 0);
        ser_lat_max = 4;
        randomize_data();
        a0 = ack_log.size();
        bus.ch_valid = 4'b0111;
        enable = 1'b1;
        for (int n = 0; n < 60 && ack_log.size() == a0; n++) step();
        check("t4_first_ack", ack_log.size() - a0, 1);
        step(1);
        rst = 1'b1;
        step(1);
        check_quiet("t4_midframe_reset");
        rst = 1'b0;
        h0 = hdr_log.size();
        wait_hdr("t4_restart", h0 + 1, 40);
        check("t4_restart_header", hlog(h0), 16'hA006);
        wait_done("t4", 80);
        ser_lat_max = 3;

        // 5: enable dropped after the header of a full frame
        randomize_data();
        h0 = hdr_log.size(); w0 = word_log.size();
        bus.ch_valid = 4'b1111;
        enable = 1'b1;
        wait_hdr("t5", h0 + 1, 40);
        enable = 1'b0;
        wait_done("t5", 120);
        check("t5_header", hlog(h0), 16'hA10F);
        check("t5_word_count", word_log.size() - w0, 5);
        bus.ch_valid = 4'b1111;
        h0 = hdr_log.size();
        step(20);
        check("t5_no_start_while_disabled", hdr_log.size() - h0, 0);
        enable = 1'b1;
        wait_done("t5_resume", 120);

        // 6: serializer not ready at IDLE
        enable = 1'b0;
        ser_hold_low = 1'b1;
        step(3);
        h0 = hdr_log.size();
        bus.ch_valid = 4'b0001;
        enable = 1'b1;
        step(10);
        check("t6_no_start_until_ready", hdr_log.size() - h0, 0);
        ser_hold_low = 1'b0;
        wait_hdr("t6", h0 + 1, 20);
        check("t6_header", hlog(h0), 16'hA301);
        wait_done("t6", 40);

        // Randomized phase: the per-cycle compare carries the checking
        for (int n = 0; n < 4000; n++) begin
            randomize_data();
            for (int i = 0; i < NUM_CH; i++)
                if (!bus.ch_valid[i] && $urandom_range(7, 0) == 0) bus.ch_valid[i] = 1'b1;
            enable       = ($urandom_range(15, 0) != 0);
            ser_lat_max  = $urandom_range(4, 1);
            ser_stuck    = ($urandom_range(299, 0) == 0) || (ser_stuck && $urandom_range(19, 0) != 0);
            ser_hold_low = ($urandom_range(199, 0) == 0) || (ser_hold_low && $urandom_range(9, 0) != 0);
            rst          = ($urandom_range(499, 0) == 0);
            step();
        end
        rst = 1'b0; enable = 1'b0; ser_stuck = 1'b0; ser_hold_low = 1'b0;
        bus.ch_valid = '0;
        step(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
